// File: rtl/mpr_ctx_pkg.sv
// Shared types and constants for the MPR context scheduler.
package mpr_ctx_pkg;

  localparam int unsigned DEF_NUM_SLOTS = 4;
  localparam int unsigned ADDR_W        = 32;

  // Pipeline mux select encoding.
  localparam logic MPR_PATH    = 1'b0;
  localparam logic NORMAL_PATH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_e;

endpackage

// File: rtl/mpr_prio_enc.sv
// Lowest-index-first priority encoder.
//   req     : request vector
//   valid_c : any request bit set (combinational)
//   idx_c   : index of the lowest set bit, 0 when none (combinational)
module mpr_prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         valid_c,
  output logic [W-1:0] idx_c
);

  // Walk from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid_c = 1'b1;
        idx_c   = W'(i);
      end
    end
  end

endmodule

// File: rtl/mpr_ctx_scheduler.sv
// Schedules saves of suspended pipeline contexts into MPR slots and restores
// them once the address they wait on is freed.
//   ctx_req/ctx_addr        : save request (held until ctx_ack) and miss address
//   freed_valid/freed_addr  : strobe announcing a freed address
//   slot_save/slot_restore  : one-hot strobes to the MPR slots
//   path_sel                : pipeline mux select (MPR_PATH during save/restore)
//   ctx_ack/resume_valid    : completion pulses; resume_slot names the slot
//   ctx_stall               : combinational, request pending with all slots locked
//   freed_miss              : freed address matched no waiting slot
//   lock_vec                : current lock bit per slot
module mpr_ctx_scheduler
  import mpr_ctx_pkg::*;
#(
  parameter int unsigned NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int unsigned SLOT_IDX_W = $clog2(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctx_req,
  input  logic [ADDR_W-1:0]     ctx_addr,
  input  logic                  freed_valid,
  input  logic [ADDR_W-1:0]     freed_addr,
  output logic [NUM_SLOTS-1:0]  slot_save,
  output logic [NUM_SLOTS-1:0]  slot_restore,
  output logic                  path_sel,
  output logic                  ctx_ack,
  output logic                  ctx_stall,
  output logic                  resume_valid,
  output logic [SLOT_IDX_W-1:0] resume_slot,
  output logic                  freed_miss,
  output logic [NUM_SLOTS-1:0]  lock_vec
);

  localparam logic [NUM_SLOTS-1:0] ONE_HOT0 = NUM_SLOTS'(1);

  state_e                state;
  logic [SLOT_IDX_W-1:0] cur_slot;
  logic [ADDR_W-1:0]     save_addr;
  logic [NUM_SLOTS-1:0]  lock_q;
  logic [NUM_SLOTS-1:0]  ready_q;
  logic [ADDR_W-1:0]     tag_q [NUM_SLOTS];

  logic                  free_valid_c;
  logic [SLOT_IDX_W-1:0] free_idx_c;
  logic                  rdy_valid_c;
  logic [SLOT_IDX_W-1:0] rdy_idx_c;
  logic [NUM_SLOTS-1:0]  match_c;
  logic [NUM_SLOTS-1:0]  ready_nxt_c;

  mpr_prio_enc #(.N(NUM_SLOTS), .W(SLOT_IDX_W)) u_free_enc (
    .req     (~lock_q),
    .valid_c (free_valid_c),
    .idx_c   (free_idx_c)
  );

  mpr_prio_enc #(.N(NUM_SLOTS), .W(SLOT_IDX_W)) u_ready_enc (
    .req     (ready_q),
    .valid_c (rdy_valid_c),
    .idx_c   (rdy_idx_c)
  );

  // Tag compare against registered state: a slot being saved is not yet
  // locked, and an already-ready slot is excluded.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match_c[i] = freed_valid && lock_q[i] && !ready_q[i] && (tag_q[i] == freed_addr);
    end
  end

  // New ready bits from the freed strobe, minus the slot being restored.
  always_comb begin
    ready_nxt_c = ready_q | match_c;
    if (state == ST_RESTORE) begin
      ready_nxt_c = ready_nxt_c & ~(ONE_HOT0 << cur_slot);
    end
  end

  assign ctx_stall = ctx_req && (&lock_q);
  assign lock_vec  = lock_q;

  // FSM, slot bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cur_slot     <= '0;
      save_addr    <= '0;
      lock_q       <= '0;
      ready_q      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) tag_q[i] <= '0;
      slot_save    <= '0;
      slot_restore <= '0;
      path_sel     <= NORMAL_PATH;
      ctx_ack      <= 1'b0;
      resume_valid <= 1'b0;
      resume_slot  <= '0;
      freed_miss   <= 1'b0;
    end else begin
      slot_save    <= '0;
      slot_restore <= '0;
      path_sel     <= NORMAL_PATH;
      ctx_ack      <= 1'b0;
      resume_valid <= 1'b0;
      freed_miss   <= freed_valid && (match_c == '0);
      ready_q      <= ready_nxt_c;

      case (state)
        ST_IDLE: begin
          if (rdy_valid_c) begin
            state        <= ST_RESTORE;
            cur_slot     <= rdy_idx_c;
            slot_restore <= ONE_HOT0 << rdy_idx_c;
            path_sel     <= MPR_PATH;
            resume_valid <= 1'b1;
            resume_slot  <= rdy_idx_c;
          end else if (ctx_req && !ctx_ack && free_valid_c) begin
            // The ack cycle still sees the old request high; skip it.
            state     <= ST_SAVE;
            cur_slot  <= free_idx_c;
            save_addr <= ctx_addr;
            slot_save <= ONE_HOT0 << free_idx_c;
            path_sel  <= MPR_PATH;
          end
        end
        ST_SAVE: begin
          lock_q[cur_slot] <= 1'b1;
          tag_q[cur_slot]  <= save_addr;
          ctx_ack          <= 1'b1;
          state            <= ST_IDLE;
        end
        ST_RESTORE: begin
          lock_q[cur_slot] <= 1'b0;
          state            <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpr_ctx_scheduler.sv
// Directed self-checking bench for mpr_ctx_scheduler (NUM_SLOTS = 4).
module tb_mpr_ctx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctx_req;
  logic [31:0] ctx_addr;
  logic        freed_valid;
  logic [31:0] freed_addr;
  logic [3:0]  slot_save;
  logic [3:0]  slot_restore;
  logic        path_sel;
  logic        ctx_ack;
  logic        ctx_stall;
  logic        resume_valid;
  logic [1:0]  resume_slot;
  logic        freed_miss;
  logic [3:0]  lock_vec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mpr_ctx_scheduler #(.NUM_SLOTS(4), .SLOT_IDX_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctx_req      (ctx_req),
    .ctx_addr     (ctx_addr),
    .freed_valid  (freed_valid),
    .freed_addr   (freed_addr),
    .slot_save    (slot_save),
    .slot_restore (slot_restore),
    .path_sel     (path_sel),
    .ctx_ack      (ctx_ack),
    .ctx_stall    (ctx_stall),
    .resume_valid (resume_valid),
    .resume_slot  (resume_slot),
    .freed_miss   (freed_miss),
    .lock_vec     (lock_vec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Plain save: SAVE cycle, then ack cycle, then request dropped.
  task automatic do_save(input logic [31:0] addr, input logic [3:0] exp_save);
    ctx_req  = 1'b1;
    ctx_addr = addr;
    tick();
    chk("save_strobe", 32'(slot_save), 32'(exp_save));
    tick();
    chk("save_ack", 32'(ctx_ack), 32'd1);
    ctx_req = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ctx_req = 1'b0;
    freed_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    ctx_addr   = '0;
    freed_addr = '0;
    do_reset();
    chk("rst_lock", 32'(lock_vec), 32'h0);
    chk("rst_path", 32'(path_sel), 32'd1);
    chk("rst_save", 32'(slot_save), 32'h0);
    chk("rst_restore", 32'(slot_restore), 32'h0);
    chk("rst_ack", 32'(ctx_ack), 32'd0);
    chk("rst_resume", 32'(resume_valid), 32'd0);
    chk("rst_miss", 32'(freed_miss), 32'd0);

    // First save lands slot 0; request held through ack starts no new save.
    ctx_req  = 1'b1;
    ctx_addr = 32'h1000;
    tick();
    chk("s0_save", 32'(slot_save), 32'h1);
    chk("s0_path", 32'(path_sel), 32'd0);
    chk("s0_lock_pre", 32'(lock_vec), 32'h0);
    tick();
    chk("s0_ack", 32'(ctx_ack), 32'd1);
    chk("s0_lock", 32'(lock_vec), 32'h1);
    chk("s0_path_back", 32'(path_sel), 32'd1);
    ctx_addr = 32'h2000;
    tick();
    chk("b2b_no_save", 32'(slot_save), 32'h0);
    chk("b2b_ack_pulse", 32'(ctx_ack), 32'd0);
    tick();
    chk("b2b_save", 32'(slot_save), 32'h2);
    tick();
    chk("b2b_ack", 32'(ctx_ack), 32'd1);
    chk("b2b_lock", 32'(lock_vec), 32'h3);
    ctx_req = 1'b0;
    tick();

    do_save(32'h3000, 4'h4);
    do_save(32'h4000, 4'h8);
    chk("full_lock", 32'(lock_vec), 32'hF);

    // Fifth request stalls until 0x2000 frees slot 1.
    ctx_req  = 1'b1;
    ctx_addr = 32'h5000;
    #1;
    chk("stall", 32'(ctx_stall), 32'd1);
    tick();
    chk("stall_no_save", 32'(slot_save), 32'h0);
    tick();
    chk("stall_no_ack", 32'(ctx_ack), 32'd0);
    freed_valid = 1'b1;
    freed_addr  = 32'h2000;
    tick();
    freed_valid = 1'b0;
    chk("free_hit_nomiss", 32'(freed_miss), 32'd0);
    tick();
    chk("rst1_restore", 32'(slot_restore), 32'h2);
    chk("rst1_valid", 32'(resume_valid), 32'd1);
    chk("rst1_slot", 32'(resume_slot), 32'd1);
    chk("rst1_path", 32'(path_sel), 32'd0);
    tick();
    chk("rst1_lock", 32'(lock_vec), 32'hD);
    chk("rst1_unstall", 32'(ctx_stall), 32'd0);
    chk("rst1_pulse", 32'(resume_valid), 32'd0);
    tick();
    chk("fifth_save", 32'(slot_save), 32'h2);
    tick();
    chk("fifth_ack", 32'(ctx_ack), 32'd1);
    chk("fifth_lock", 32'(lock_vec), 32'hF);
    ctx_req = 1'b0;
    tick();

    // Unmatched free address.
    freed_valid = 1'b1;
    freed_addr  = 32'hDEAD;
    tick();
    freed_valid = 1'b0;
    chk("miss_pulse", 32'(freed_miss), 32'd1);
    chk("miss_lock", 32'(lock_vec), 32'hF);
    tick();
    chk("miss_clear", 32'(freed_miss), 32'd0);
    chk("miss_no_restore", 32'(slot_restore), 32'h0);

    // Two slots waiting on the same address restore in index order.
    do_reset();
    do_save(32'h5000, 4'h1);
    do_save(32'h6000, 4'h2);
    do_save(32'h5000, 4'h4);
    chk("dual_lock", 32'(lock_vec), 32'h7);
    freed_valid = 1'b1;
    freed_addr  = 32'h5000;
    tick();
    freed_valid = 1'b0;
    chk("dual_nomiss", 32'(freed_miss), 32'd0);
    tick();
    chk("dual_r0", 32'(slot_restore), 32'h1);
    chk("dual_r0_slot", 32'(resume_slot), 32'd0);
    tick();
    chk("dual_mid_lock", 32'(lock_vec), 32'h6);
    tick();
    chk("dual_r2", 32'(slot_restore), 32'h4);
    chk("dual_r2_slot", 32'(resume_slot), 32'd2);
    tick();
    chk("dual_end_lock", 32'(lock_vec), 32'h2);

    // Ready slot and request in the same idle cycle: restore goes first.
    freed_valid = 1'b1;
    freed_addr  = 32'h6000;
    tick();
    freed_valid = 1'b0;
    ctx_req  = 1'b1;
    ctx_addr = 32'h7000;
    tick();
    chk("prio_restore", 32'(slot_restore), 32'h2);
    chk("prio_no_save", 32'(slot_save), 32'h0);
    tick();
    chk("prio_lock", 32'(lock_vec), 32'h0);
    tick();
    chk("prio_save", 32'(slot_save), 32'h1);
    tick();
    chk("prio_ack", 32'(ctx_ack), 32'd1);
    chk("prio_save_lock", 32'(lock_vec), 32'h1);
    ctx_req = 1'b0;
    tick();

    // Reset during SAVE abandons it.
    ctx_req  = 1'b1;
    ctx_addr = 32'h8000;
    tick();
    chk("abort_save", 32'(slot_save), 32'h2);
    rst_n = 1'b0;
    tick();
    chk("abort_ack", 32'(ctx_ack), 32'd0);
    chk("abort_lock", 32'(lock_vec), 32'h0);
    chk("abort_path", 32'(path_sel), 32'd1);
    chk("abort_strobe", 32'(slot_save), 32'h0);
    rst_n   = 1'b1;
    ctx_req = 1'b0;
    tick();
    chk("abort_ack_after", 32'(ctx_ack), 32'd0);
    chk("abort_lock_after", 32'(lock_vec), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
